// File: rtl/board_io_pkg.sv
// board_io_pkg
//   Shared constants and types for the board input conditioner.
//   - RAM_ADDR_W / DISPLAY_W : widths of the switch buses.
//   - DEBOUNCE_CYCLES_DEF    : default stable-cycle count before an input is accepted.
//   - RST_STRETCH_DEF        : default number of cycles rst is held after its sources drop.
//   - cond_in_t              : bundle of all conditioned inputs, MSB first
//                              {ram_addr, display, frequency, btn_rst, btn_pcenclr}.
package board_io_pkg;

   localparam int RAM_ADDR_W          = 6;
   localparam int DISPLAY_W           = 3;
   localparam int DEBOUNCE_CYCLES_DEF = 1000000;
   localparam int RST_STRETCH_DEF     = 4000000;

   typedef struct packed {
      logic [RAM_ADDR_W-1:0] ram_addr;
      logic [DISPLAY_W-1:0]  display;
      logic                  frequency;
      logic                  btn_rst;
      logic                  btn_pcenclr;
   } cond_in_t;

   localparam int COND_W = $bits(cond_in_t);

   // Bits [COND_W-1:2] are switches (they raise sw_event); [1:0] are buttons.
   localparam int BTN_BITS = 2;

endpackage

// File: rtl/debounce_cell.sv
// debounce_cell
//   Conditions one raw board input bit: 2-flop synchronizer, then a stable
//   counter that only lets a new level through after DEBOUNCE_CYCLES
//   consecutive differing samples.
//   Macro INPUT_DEBOUNCE_EN: when undefined the counter is removed and the
//   accepted state simply follows the synchronizer (2-edge latency).
// Ports:
//   clk    in  board clock
//   rst_n  in  asynchronous active-low reset
//   din    in  raw asynchronous input bit
//   state  out accepted (debounced) level
//   upd    out high in the cycle before state changes; the new value is
//              visible after the next rising edge
module debounce_cell
   import board_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic state,
   output logic upd
);

`ifdef INPUT_DEBOUNCE_EN

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_reg;
   logic             sync2_reg;
   logic             state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             differ;

   assign differ = sync2_reg ^ state_reg;
   // The final differing sample both commits the new level and clears the
   // counter, so the counter never wraps.
   assign upd    = differ && (cnt_reg == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         state_reg <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         sync1_reg <= din;
         sync2_reg <= sync1_reg;
         if (!differ) begin
            cnt_reg <= '0;
         end else if (upd) begin
            state_reg <= sync2_reg;
            cnt_reg   <= '0;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

`else

   // Without debouncing the state flop doubles as the second synchronizer
   // stage, which gives the 2-edge latency.
   logic sync1_reg;
   logic state_reg;

   assign upd = sync1_reg ^ state_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= 1'b0;
         state_reg <= 1'b0;
      end else begin
         sync1_reg <= din;
         state_reg <= sync1_reg;
      end
   end

`endif

   assign state = state_reg;

endmodule

// File: rtl/board_input_cond.sv
// board_input_cond
//   Synchronizes and debounces the board switches/buttons, stretches the
//   pipeline reset and flags switch changes. Everything runs on the
//   undivided board clock.
//   Macro INPUT_DEBOUNCE_EN: defined = full debounce; undefined = 2-edge
//   pass-through (DEBOUNCE_CYCLES ignored), stretcher and sw_event unchanged.
// Ports:
//   clk              in  board clock
//   rst_n            in  asynchronous active-low reset
//   sw_ram_addr_in   in  raw DM display address switches [5:0]
//   sw_display_in    in  raw display selector switches [2:0]
//   sw_frequency_in  in  raw clock speed select switch
//   btn_rst_in       in  raw pipeline reset button
//   btn_pcenclr_in   in  raw PC-enable clear button
//   ram_addr         out debounced address [5:0]
//   display          out debounced selector [2:0]
//   frequency        out debounced speed select
//   rst              out active-high stretched pipeline reset
//   PCenclr          out debounced button level
//   sw_event         out one-cycle pulse when any switch output changes
module board_input_cond
   import board_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int RST_STRETCH     = RST_STRETCH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [RAM_ADDR_W-1:0] sw_ram_addr_in,
   input  logic [DISPLAY_W-1:0]  sw_display_in,
   input  logic                  sw_frequency_in,
   input  logic                  btn_rst_in,
   input  logic                  btn_pcenclr_in,
   output logic [RAM_ADDR_W-1:0] ram_addr,
   output logic [DISPLAY_W-1:0]  display,
   output logic                  frequency,
   output logic                  rst,
   output logic                  PCenclr,
   output logic                  sw_event
);

   localparam int               STR_W    = $clog2(RST_STRETCH + 1);
   localparam logic [STR_W-1:0] STR_LOAD = STR_W'(RST_STRETCH);

   cond_in_t            raw_in;
   cond_in_t            cond_st;
   logic [COND_W-1:0]   state_bus;
   logic [COND_W-1:0]   upd_bus;
   logic [STR_W-1:0]    stretch_reg;
   logic                sw_event_reg;
   logic                stretch_load;

   assign raw_in.ram_addr    = sw_ram_addr_in;
   assign raw_in.display     = sw_display_in;
   assign raw_in.frequency   = sw_frequency_in;
   assign raw_in.btn_rst     = btn_rst_in;
   assign raw_in.btn_pcenclr = btn_pcenclr_in;

   generate
      for (genvar gi = 0; gi < COND_W; gi++) begin : g_cell
         debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (raw_in[gi]),
            .state (state_bus[gi]),
            .upd   (upd_bus[gi])
         );
      end
   endgenerate

   assign cond_st = cond_in_t'(state_bus);

   // Reload while the debounced button is held, and also on the cycle it is
   // being accepted, so rst rises on the same edge the button qualifies.
   // On release the final reload happens on the edge the state drops, so
   // rst falls exactly RST_STRETCH cycles later.
   assign stretch_load = cond_st.btn_rst | upd_bus[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stretch_reg  <= STR_LOAD;
         sw_event_reg <= 1'b0;
      end else begin
         sw_event_reg <= |upd_bus[COND_W-1:BTN_BITS];
         if (stretch_load) begin
            stretch_reg <= STR_LOAD;
         end else if (stretch_reg != '0) begin
            stretch_reg <= stretch_reg - 1'b1;
         end
      end
   end

   assign ram_addr  = cond_st.ram_addr;
   assign display   = cond_st.display;
   assign frequency = cond_st.frequency;
   assign PCenclr   = cond_st.btn_pcenclr;
   assign rst       = (stretch_reg != '0);
   assign sw_event  = sw_event_reg;

endmodule

// File: tb/tb_board_input_cond.sv
// tb_board_input_cond
//   Directed test of board_input_cond with DEBOUNCE_CYCLES=4, RST_STRETCH=8.
//   Expected latency follows INPUT_DEBOUNCE_EN: 2+DEBOUNCE_CYCLES edges when
//   defined, 2 edges when not.
module tb_board_input_cond;

   localparam int DC = 4;
   localparam int RS = 8;
`ifdef INPUT_DEBOUNCE_EN
   localparam bit DEB = 1'b1;
   localparam int LAT = 2 + DC;
`else
   localparam bit DEB = 1'b0;
   localparam int LAT = 2;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] sw_ram_addr_in;
   logic [2:0] sw_display_in;
   logic       sw_frequency_in;
   logic       btn_rst_in;
   logic       btn_pcenclr_in;
   logic [5:0] ram_addr;
   logic [2:0] display;
   logic       frequency;
   logic       rst;
   logic       PCenclr;
   logic       sw_event;

   int vectors = 0;
   int errors  = 0;

   board_input_cond #(
      .DEBOUNCE_CYCLES (DC),
      .RST_STRETCH     (RS)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .sw_ram_addr_in  (sw_ram_addr_in),
      .sw_display_in   (sw_display_in),
      .sw_frequency_in (sw_frequency_in),
      .btn_rst_in      (btn_rst_in),
      .btn_pcenclr_in  (btn_pcenclr_in),
      .ram_addr        (ram_addr),
      .display         (display),
      .frequency       (frequency),
      .rst             (rst),
      .PCenclr         (PCenclr),
      .sw_event        (sw_event)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // PCenclr stimulus level driven before edge e (1-based).
   function automatic logic pc_lvl(input int e);
      if (e <= 10) return (((e - 1) % 4) < 2);
      return 1'b1;
   endfunction

   initial begin
      rst_n           = 1'b0;
      sw_ram_addr_in  = '0;
      sw_display_in   = '0;
      sw_frequency_in = 1'b0;
      btn_rst_in      = 1'b0;
      btn_pcenclr_in  = 1'b0;

      // Reset state
      repeat (3) step();
      check_val("rst_in_reset", rst, 1);
      check_val("ram_addr_reset", ram_addr, 0);
      check_val("display_reset", display, 0);
      check_val("frequency_reset", frequency, 0);
      check_val("pcenclr_reset", PCenclr, 0);
      check_val("sw_event_reset", sw_event, 0);

      // Stretch after rst_n release: high for exactly RS edges
      rst_n = 1'b1;
      for (int k = 1; k <= RS + 1; k++) begin
         step();
         check_val($sformatf("rst_stretch_e%0d", k), rst, (k < RS) ? 1 : 0);
      end

      // ram_addr 0x00 -> 0x2A
      sw_ram_addr_in = 6'h2A;
      for (int k = 1; k <= LAT + 1; k++) begin
         step();
         check_val($sformatf("ram_addr_e%0d", k), ram_addr, (k >= LAT) ? 32'h2A : 32'h0);
         check_val($sformatf("sw_event_addr_e%0d", k), sw_event, (k == LAT) ? 1 : 0);
      end
      check_val("display_unchanged", display, 0);
      check_val("frequency_unchanged", frequency, 0);

      // 3-cycle glitch on frequency
      for (int k = 1; k <= 10; k++) begin
         sw_frequency_in = (k <= 3);
         step();
         check_val($sformatf("freq_glitch_e%0d", k), frequency,
                   (!DEB && k >= 2 && k <= 4) ? 1 : 0);
         check_val($sformatf("sw_event_glitch_e%0d", k), sw_event,
                   (!DEB && (k == 2 || k == 5)) ? 1 : 0);
      end

      // Reset button held 20 cycles
      check_val("rst_idle_before_btn", rst, 0);
      btn_rst_in = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step();
         check_val($sformatf("rst_btn_held_e%0d", k), rst, (k >= LAT) ? 1 : 0);
      end
      btn_rst_in = 1'b0;
      for (int k = 1; k <= LAT + RS + 2; k++) begin
         step();
         check_val($sformatf("rst_btn_rel_e%0d", k), rst, (k < LAT + RS) ? 1 : 0);
      end

      // Bouncing PC-enable clear button, then held high
      for (int e = 1; e <= 16; e++) begin
         btn_pcenclr_in = pc_lvl(e);
         step();
         if (DEB) begin
            check_val($sformatf("pcenclr_e%0d", e), PCenclr, (e >= 8 + LAT) ? 1 : 0);
         end else begin
            check_val($sformatf("pcenclr_e%0d", e), PCenclr,
                      (e >= 2) ? {31'b0, pc_lvl(e - 1)} : 0);
         end
         check_val($sformatf("sw_event_btn_e%0d", e), sw_event, 0);
      end

      // display change interrupted by rst_n pulse at edge 3
      sw_display_in = 3'b101;
      step();
      step();
      rst_n = 1'b0;
      step();
      check_val("display_in_reset", display, 0);
      check_val("rst_in_pulse", rst, 1);
      check_val("pcenclr_in_reset", PCenclr, 0);
      rst_n = 1'b1;
      for (int k = 1; k <= LAT + 1; k++) begin
         step();
         check_val($sformatf("display_after_rel_e%0d", k), display, (k >= LAT) ? 5 : 0);
         check_val($sformatf("sw_event_disp_e%0d", k), sw_event, (k == LAT) ? 1 : 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
